delay_timer: RTL and testbench

Programmable hardware delay generator for the 8-bit processor; sits directly downstream of the data memory, d_mem. On start it reads three preload bytes from consecutive d_mem addresses: inner, middle and outer count. It then runs a three-level nested up-counter, with each level counting from its preload to 255. It signals completion with a one-cycle done pulse. This replaces the software triple-loop delay (R0/R1/R2) with a fixed-latency block.

---
 rtl/delay_timer.sv | 123 ++++++++++++
 tb/tb_delay_timer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_timer.sv
// delay_timer: three-level nested up-counter delay generator.
// Loads preloads from d_mem, counts to 255 per level, pulses done.
module delay_timer #(
  parameter logic [7:0] BASE_ADDR = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] data,
  output logic [7:0] address,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD0,
    LOAD1,
    LOAD2,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0] p0, p1, p2;
  logic [7:0] c0, c1, c2;
  logic       all_max;

  assign all_max = (c0 == 8'hFF) &&
                   (c1 == 8'hFF) &&
                   (c2 == 8'hFF);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and state-decoded outputs; stop overrides everything
  always_comb begin
    state_nxt = state;
    address   = BASE_ADDR;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = LOAD0;
      end
      LOAD0: begin
        busy      = 1'b1;
        state_nxt = LOAD1;
      end
      LOAD1: begin
        address   = BASE_ADDR + 8'd1;
        busy      = 1'b1;
        state_nxt = LOAD2;
      end
      LOAD2: begin
        address   = BASE_ADDR + 8'd2;
        busy      = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (all_max) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (stop) state_nxt = IDLE;
  end

  // Preload capture and nested counting; everything holds on stop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0 <= 8'd0;
      p1 <= 8'd0;
      p2 <= 8'd0;
      c0 <= 8'd0;
      c1 <= 8'd0;
      c2 <= 8'd0;
    end else if (!stop) begin
      unique case (state)
        LOAD0: begin
          p0 <= data;
          c0 <= data;
        end
        LOAD1: begin
          p1 <= data;
          c1 <= data;
        end
        LOAD2: begin
          p2 <= data;
          c2 <= data;
        end
        RUN: begin
          if (!all_max) begin
            if (c0 != 8'hFF) begin
              c0 <= c0 + 8'd1;
            end else begin
              c0 <= p0;
              if (c1 != 8'hFF) begin
                c1 <= c1 + 8'd1;
              end else begin
                c1 <= p1;
                if (c2 != 8'hFF) c2 <= c2 + 8'd1;
                else             c2 <= p2;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_timer.sv
// tb_delay_timer: scenario tasks with a done-cycle scoreboard.
// Two instances cover BASE_ADDR=0 and the wrapping BASE_ADDR=254.
module tb_delay_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;
  logic       busy_a, done_a;
  logic       busy_b, done_b;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign data_a = mem_a[addr_a];
  assign data_b = mem_b[addr_b];

  delay_timer #(.BASE_ADDR(8'd0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .stop(stop), .address(addr_a),
    .data(data_a), .busy(busy_a), .done(done_a)
  );

  delay_timer #(.BASE_ADDR(8'd254)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .stop(1'b0), .address(addr_b),
    .data(data_b), .busy(busy_b), .done(done_b)
  );

  task automatic set_mem_a(input logic [7:0] a,
                           input logic [7:0] b,
                           input logic [7:0] c);
    mem_a[0] = a;
    mem_a[1] = b;
    mem_a[2] = c;
  endtask

  // start is sampled at edge k; returns k
  task automatic pulse_start_a(output int k);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    start_a = 1'b0;
  endtask

  // waits for a done pulse; returns its cycle number or -1
  task automatic wait_done(input bit sel_b, input int budget,
                           output int at);
    bit seen;
    seen = 1'b0;
    at = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if ((sel_b ? done_b : done_a) === 1'b1) begin
        at = cyc + 1;
        seen = 1'b1;
      end
    end
  endtask

  function automatic int pop_exp();
    if (exp_q.size() == 0) return -2;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || addr_a !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_a: busy=%b done=%b addr=%0d need 0 0 0",
               busy_a, done_a, addr_a);
    end
    n_chk++;
    if (busy_b !== 1'b0 || done_b !== 1'b0 || addr_b !== 8'd254) begin
      n_fail++;
      $display("FAIL reset_b: busy=%b done=%b addr=%0d need 0 0 254",
               busy_b, done_b, addr_b);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int k, e;
    logic [7:0] ea;
    logic eb, ed;
    set_mem_a(8'd254, 8'd254, 8'd254);
    pulse_start_a(k);
    exp_q.push_back(k + 12);
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      ea = (i <= 3) ? 8'(i - 1) : 8'd0;
      eb = (i <= 11);
      ed = (i == 12);
      n_chk++;
      if (addr_a !== ea || busy_a !== eb || done_a !== ed) begin
        n_fail++;
        $display("FAIL basic k+%0d: addr=%0d busy=%b done=%b need %0d %b %b",
                 i, addr_a, busy_a, done_a, ea, eb, ed);
      end
      if (done_a === 1'b1) begin
        e = pop_exp();
        n_chk++;
        if (cyc + 1 !== e) begin
          n_fail++;
          $display("FAIL basic_done_cycle: got %0d need %0d", cyc + 1, e);
        end
      end
    end
  endtask

  task automatic test_min();
    int k, at, e;
    set_mem_a(8'd255, 8'd255, 8'd255);
    pulse_start_a(k);
    exp_q.push_back(k + 5);
    wait_done(1'b0, 20, at);
    e = pop_exp();
    n_chk++;
    if (at !== e) begin
      n_fail++;
      $display("FAIL min_n1: done at %0d need %0d", at, e);
    end
  endtask

  task automatic test_n256();
    int k, at, e;
    set_mem_a(8'd0, 8'd255, 8'd255);
    pulse_start_a(k);
    exp_q.push_back(k + 260);
    wait_done(1'b0, 400, at);
    e = pop_exp();
    n_chk++;
    if (at !== e) begin
      n_fail++;
      $display("FAIL n256: done at %0d need %0d", at, e);
    end
  endtask

  task automatic test_wrap();
    int k, at, e;
    logic [7:0] ea [3];
    ea[0] = 8'd254;
    ea[1] = 8'd255;
    ea[2] = 8'd0;
    mem_b[254] = 8'd253;
    mem_b[255] = 8'd254;
    mem_b[0]   = 8'd255;
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    start_b = 1'b0;
    exp_q.push_back(k + 10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (addr_b !== ea[i]) begin
        n_fail++;
        $display("FAIL wrap_addr k+%0d: got %0d need %0d",
                 i + 1, addr_b, ea[i]);
      end
    end
    wait_done(1'b1, 40, at);
    e = pop_exp();
    n_chk++;
    if (at !== e) begin
      n_fail++;
      $display("FAIL wrap_done: done at %0d need %0d", at, e);
    end
  endtask

  task automatic test_back_to_back();
    int k, k2, at, e, extra;
    set_mem_a(8'd254, 8'd254, 8'd254);
    pulse_start_a(k);
    exp_q.push_back(k + 12);
    repeat (4) @(negedge clk);
    start_a = 1'b1;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (addr_a !== 8'd0 || done_a !== 1'b0 || busy_a !== 1'b1)
        extra++;
    end
    start_a = 1'b0;
    n_chk++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL start_in_run: %0d bad cycles need 0", extra);
    end
    wait_done(1'b0, 40, at);
    e = pop_exp();
    n_chk++;
    if (at !== e) begin
      n_fail++;
      $display("FAIL b2b_first: done at %0d need %0d", at, e);
    end
    @(negedge clk);
    n_chk++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL done_width: done=%b busy=%b need 0 0",
               done_a, busy_a);
    end
    start_a = 1'b1;
    @(posedge clk);
    #1;
    k2 = cyc;
    start_a = 1'b0;
    exp_q.push_back(k2 + 12);
    wait_done(1'b0, 40, at);
    e = pop_exp();
    n_chk++;
    if (at !== e) begin
      n_fail++;
      $display("FAIL b2b_second: done at %0d need %0d", at, e);
    end
  endtask

  task automatic test_stop();
    int k, dones;
    set_mem_a(8'd254, 8'd254, 8'd254);
    pulse_start_a(k);
    repeat (5) @(negedge clk);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || addr_a !== 8'd0) begin
      n_fail++;
      $display("FAIL stop_idle: busy=%b done=%b addr=%0d need 0 0 0",
               busy_a, done_a, addr_a);
    end
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_a === 1'b1) dones++;
    end
    n_chk++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL stop_no_done: %0d pulses need 0", dones);
    end
    stop = 1'b1;
    start_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if (busy_a !== 1'b0) begin
        n_fail++;
        $display("FAIL stop_start_idle: busy=%b need 0", busy_a);
      end
    end
    stop = 1'b0;
    start_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int k, at, e, dones;
    set_mem_a(8'd254, 8'd254, 8'd254);
    pulse_start_a(k);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || addr_a !== 8'd0) begin
      n_fail++;
      $display("FAIL async_rst: busy=%b done=%b addr=%0d need 0 0 0",
               busy_a, done_a, addr_a);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done_a === 1'b1) dones++;
    end
    n_chk++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL rst_no_done: %0d pulses need 0", dones);
    end
    pulse_start_a(k);
    exp_q.push_back(k + 12);
    wait_done(1'b0, 40, at);
    e = pop_exp();
    n_chk++;
    if (at !== e) begin
      n_fail++;
      $display("FAIL rst_restart: done at %0d need %0d", at, e);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'd0;
      mem_b[i] = 8'd0;
    end
    test_reset();
    test_basic();
    test_min();
    test_n256();
    test_wrap();
    test_back_to_back();
    test_stop();
    test_async_reset();
    n_chk++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d left need 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
